// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue between instruction memory and IF/ID.
// Issues sequential fetches with at most one request outstanding, buffers
// returned {pc, instruction} pairs in a small FIFO and hands them to IF/ID
// through valid/ready. A branch redirect flushes the queue and restarts
// fetch at the new PC; a response belonging to a flushed request is dropped.
module instruction_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    output logic                       imem_req,
    output logic [63:0]                imem_addr,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_instruction,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    // FIFO storage; contents only matter where count says an entry is live
    logic [63:0]     pc_mem_q  [DEPTH];
    logic [31:0]     ins_mem_q [DEPTH];

    logic            issue_s;
    logic            push_s;
    logic            pop_s;
    logic            out_valid_s;

    // Handshake qualifiers. The slot check is conservative: with only one
    // request in flight, count cannot grow before its response returns.
    always_comb begin
        out_valid_s = (count_q != {CW{1'b0}});
        issue_s     = (state_q == IDLE) && (count_q < CW'(DEPTH))
                      && !redirect_valid && !RESET;
        push_s      = (state_q == WAIT) && imem_rvalid && !redirect_valid;
        pop_s       = out_valid_s && out_ready && !redirect_valid;
    end

    // Next-state: fetch FSM, fetch PC, FIFO pointers and count; redirect wins
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (issue_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            count_d    = {CW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
        end else begin
            if (push_s) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end else begin
                fetch_pc_d = fetch_pc_q;
                wr_ptr_d   = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CW'(1);
            end else if (!push_s && pop_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO write port: store the returned word tagged with its fetch PC
    always_ff @(posedge CLOCK) begin
        if (push_s && !RESET) begin
            pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
            ins_mem_q[wr_ptr_q] <= imem_rdata;
        end else begin
            pc_mem_q[wr_ptr_q]  <= pc_mem_q[wr_ptr_q];
            ins_mem_q[wr_ptr_q] <= ins_mem_q[wr_ptr_q];
        end
    end

    assign imem_req        = issue_s;
    assign imem_addr       = fetch_pc_q;
    assign out_valid       = out_valid_s;
    assign out_pc          = pc_mem_q[rd_ptr_q];
    assign out_instruction = ins_mem_q[rd_ptr_q];
    assign occupancy       = count_q;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: a variable-latency memory model and
// a scoreboard of expected {pc, instruction} entries checked at each pop.
module tb_instruction_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_ready;
    logic [2:0]  occupancy;

    instruction_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_pc(out_pc),
        .out_instruction(out_instruction), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    // Free-running clock
    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } entry_t;

    int          errors = 0;
    int          checks = 0;
    entry_t      sbq[$];
    logic [63:0] req_addrs[$];
    logic [63:0] req_cycs[$];
    logic [63:0] pop_pcs[$];
    int          first_ov_cyc;
    logic [63:0] first_ov_pc;
    logic [31:0] first_ov_ins;
    int          cyc;
    logic [63:0] exp_pc;
    bit          mem_busy;
    logic [63:0] mem_addr;
    int          mem_cnt;
    bit          mem_drop;
    int          lat;
    bit          stray;
    logic        s_req;
    logic [63:0] s_addr;
    logic        s_ov;
    logic [2:0]  s_occ;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hF8400020 ^ a[31:0];
    endfunction

    function automatic logic [63:0] q_at(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return {64{1'b1}};
    endfunction

    // One clock cycle: drive memory response, sample outputs mid-cycle,
    // update the scoreboard, then advance past the next rising edge.
    task automatic step();
        bit          resp;
        logic [63:0] raddr;
        entry_t      e;
        resp  = 1'b0;
        raddr = mem_addr;
        if (mem_busy && mem_cnt == 0) begin
            resp        = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_addr);
            mem_busy    = 1'b0;
        end else begin
            imem_rvalid = stray;
            imem_rdata  = stray ? 32'hDEADBEEF : 32'h0;
            if (mem_busy) mem_cnt--;
        end
        #2;
        s_req  = imem_req;
        s_addr = imem_addr;
        s_ov   = out_valid;
        s_occ  = occupancy;
        if (RESET) begin
            check_val("req_in_reset", 64'(imem_req), 64'd0);
            sbq.delete();
            req_addrs.delete();
            req_cycs.delete();
            pop_pcs.delete();
            first_ov_cyc = -1;
            exp_pc   = RESET_PC;
            mem_busy = 1'b0;
            cyc      = 0;
        end else begin
            check_val("occupancy", 64'(occupancy), 64'(sbq.size()));
            check_val("out_valid", 64'(out_valid), 64'(sbq.size() != 0));
            if (out_valid && first_ov_cyc < 0) begin
                first_ov_cyc = cyc;
                first_ov_pc  = out_pc;
                first_ov_ins = out_instruction;
            end
            if (out_valid && out_ready && !redirect_valid && sbq.size() > 0) begin
                e = sbq.pop_front();
                check_val("pop_pc", out_pc, e.pc);
                check_val("pop_ins", 64'(out_instruction), 64'(e.ins));
                pop_pcs.push_back(out_pc);
            end
            if (resp && !mem_drop && !redirect_valid) begin
                sbq.push_back({raddr, instr_of(raddr)});
                exp_pc = raddr + 64'd4;
            end
            if (imem_req) begin
                check_val("req_addr", imem_addr, exp_pc);
                req_addrs.push_back(imem_addr);
                req_cycs.push_back(64'(cyc));
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = lat - 1;
                mem_drop = 1'b0;
            end
            if (redirect_valid) begin
                sbq.delete();
                exp_pc = redirect_pc;
                if (mem_busy) mem_drop = 1'b1;
            end
            cyc++;
        end
        stray = 1'b0;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET          = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        RESET = 1'b0;
    endtask

    // Directed scenarios
    initial begin
        RESET = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b1;
        stray = 1'b0; mem_busy = 1'b0; mem_drop = 1'b0; mem_addr = 64'h0;
        mem_cnt = 0; lat = 1; cyc = 0; first_ov_cyc = -1; exp_pc = RESET_PC;
        @(posedge CLOCK);
        #1;

        // Reset release, latency 1, always ready
        lat = 1; out_ready = 1'b1;
        do_reset();
        repeat (6) step();
        check_val("t1_req0_cyc", q_at(req_cycs, 0), 64'd0);
        check_val("t1_req1_cyc", q_at(req_cycs, 1), 64'd2);
        check_val("t1_req2_cyc", q_at(req_cycs, 2), 64'd4);
        check_val("t1_req2_addr", q_at(req_addrs, 2), 64'h8);
        check_val("t1_first_ov_cyc", 64'(first_ov_cyc), 64'd2);
        check_val("t1_first_pc", first_ov_pc, 64'h0);
        check_val("t1_first_ins", 64'(first_ov_ins), 64'hF8400020);

        // Fill while stalled, then drain
        out_ready = 1'b0;
        do_reset();
        repeat (12) step();
        check_val("t2_full_occ", 64'(s_occ), 64'd4);
        check_val("t2_full_noreq", 64'(req_addrs.size()), 64'd4);
        out_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 4; i++) begin
            check_val("t2_drain_pc", q_at(pop_pcs, i), 64'(4 * i));
        end
        check_val("t2_next_req", q_at(req_addrs, 4), 64'h10);

        // Redirect while a slow request is outstanding
        lat = 3; out_ready = 1'b1;
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        repeat (12) step();
        check_val("t3_req0", q_at(req_addrs, 0), 64'h0);
        check_val("t3_req1", q_at(req_addrs, 1), 64'h40);
        check_val("t3_first_pc", first_ov_pc, 64'h40);

        // Redirect coincident with a response at occupancy 2
        lat = 1; out_ready = 1'b0;
        do_reset();
        repeat (5) step();
        redirect_valid = 1'b1; redirect_pc = 64'h80;
        step();
        check_val("t4_occ_before", 64'(s_occ), 64'd2);
        redirect_valid = 1'b0;
        step();
        check_val("t4_occ_after", 64'(s_occ), 64'd0);
        check_val("t4_ov_after", 64'(s_ov), 64'd0);
        check_val("t4_req_after", 64'(s_req), 64'd1);
        check_val("t4_addr_after", s_addr, 64'h80);
        out_ready = 1'b1;
        repeat (6) step();

        // Push coincident with pop at occupancy 2
        lat = 1; out_ready = 1'b0;
        do_reset();
        repeat (5) step();
        out_ready = 1'b1;
        step();
        check_val("t5_occ_pushpop", 64'(s_occ), 64'd2);
        step();
        check_val("t5_occ_hold", 64'(s_occ), 64'd2);
        repeat (10) step();
        check_val("t5_npops", 64'(pop_pcs.size() >= 5), 64'd1);
        for (int i = 1; i < pop_pcs.size(); i++) begin
            check_val("t5_pc_step", pop_pcs[i] - pop_pcs[i-1], 64'd4);
        end

        // Reset while waiting on 0x8, stray response after release
        lat = 2; out_ready = 1'b1;
        do_reset();
        repeat (7) step();
        check_val("t6_pending_addr", q_at(req_addrs, 2), 64'h8);
        lat = 1;
        do_reset();
        step();
        step();
        stray = 1'b1;
        step();
        repeat (6) step();
        check_val("t6_req0", q_at(req_addrs, 0), RESET_PC);
        check_val("t6_req1_cyc", q_at(req_cycs, 1), 64'd2);
        check_val("t6_first_pc", first_ov_pc, RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_queue.md
Name: instruction_prefetch_queue

Overview:
- Decoupled fetch stage between instruction memory and the IF/ID pipeline register of the LEGv8 pipelined CPU.
- Generates sequential fetch addresses and issues them to a variable-latency instruction memory, with at most one request outstanding.
- Buffers returned {pc, instruction} pairs in a FIFO and presents them to IF/ID through a valid/ready handshake.
- A branch redirect from EX/MEM flushes the queue and restarts fetch at the new PC.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 64'h0, fetch address after reset

Ports:
- CLOCK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- redirect_valid  input  1  taken branch; flush and refetch
- redirect_pc  input  64  new fetch address, valid with redirect_valid
- imem_req  output  1  fetch request, one-cycle pulse
- imem_addr  output  64  fetch address, valid when imem_req=1
- imem_rvalid  input  1  instruction memory response valid
- imem_rdata  input  32  instruction word, valid with imem_rvalid
- out_valid  output  1  head entry valid
- out_pc  output  64  PC of head entry
- out_instruction  output  32  instruction of head entry
- out_ready  input  1  IF/ID accepts head entry
- occupancy  output  clog2(DEPTH)+1  stored entry count

Behaviour:
- State: fetch_pc (64b), FSM {IDLE, WAIT, DROP}, FIFO storage, rd/wr pointers, count.
- RESET (synchronous, dominates all other inputs):
  - fetch_pc=RESET_PC, state=IDLE, count=0, pointers=0.
  - Outputs settle at out_valid=0, occupancy=0, imem_req=0.
  - An outstanding request is abandoned; a later stray imem_rvalid arriving in IDLE is ignored.
- imem_req is combinational: state==IDLE && count<DEPTH && !redirect_valid && !RESET. imem_addr=fetch_pc.
  - Issuing moves state to WAIT on the next edge.
  - The slot check is conservative: with one request outstanding, count cannot rise before the response arrives, so no overflow is possible.
- WAIT:
  - imem_rvalid && !redirect_valid: push {fetch_pc, imem_rdata}; fetch_pc+=4 (mod 2^64); state → IDLE.
  - redirect_valid && imem_rvalid in the same cycle: response discarded; state → IDLE.
  - redirect_valid && !imem_rvalid: state → DROP.
- DROP: on imem_rvalid, discard data and go to IDLE. A redirect in DROP updates fetch_pc; state is unchanged.
- IDLE: imem_rvalid is ignored (protocol violation, no state change).
- Redirect (any state): count=0, pointers=0, fetch_pc=redirect_pc. Takes priority over push, pop and issue in the same cycle.
  - out_valid is 0 from the next cycle.
  - An out_valid&&out_ready transfer in a redirect cycle is flushed by the consumer on the same redirect. The queue does not re-present it.
- Output side:
  - out_valid = (count != 0); out_pc/out_instruction = head entry, combinational from storage.
  - Pop when out_valid && out_ready. Head data must stay stable while out_valid && !out_ready.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
  - Pointers wrap modulo DEPTH.
- Latency and throughput:
  - Response in cycle N gives out_valid=1 in cycle N+1.
  - Next request is issued in cycle N+1.
  - With 1-cycle memory latency, sustained throughput is one instruction per 2 cycles.
- occupancy = count, registered. out_valid is never 1 with occupancy=0.

Test Plan:
- Reset release, memory latency 1, out_ready=1, DEPTH=4:
  - imem_req at cycle 0 (addr 0x0), cycle 2 (0x4), cycle 4 (0x8).
  - out_valid first in cycle 2 with out_pc=0x0 and the instruction returned for 0x0, e.g. 0xF8400020.
- out_ready=0, latency 1: four responses fill the queue (occupancy=4), then imem_req stays 0.
  - Raise out_ready: entries drain in order pc 0x0, 0x4, 0x8, 0xC.
  - Next request addr=0x10.
- Latency 3, redirect_valid with redirect_pc=0x40 one cycle after the request to 0x0:
  - Late response is dropped; next imem_addr=0x40.
  - First out_pc=0x40; no entry for 0x0 ever appears.
- redirect_valid (pc=0x80) in the same cycle as imem_rvalid with occupancy=2:
  - Next cycle occupancy=0, out_valid=0.
  - Next request at 0x80.
- Occupancy 2, out_ready=1, push coincident with pop: occupancy stays 2 and the pc sequence stays strictly +4.
- RESET asserted in WAIT (request to 0x8 outstanding), stray imem_rvalid 2 cycles after release:
  - Stray response ignored.
  - First request after release at RESET_PC.
  - First out_pc=RESET_PC.
